// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiter.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_burst_lock_pick.sv
// Combinational masked MSB-first pick: prefer requesters below ptr, else plain
// MSB-first over all remaining requesters.
module rr_mask_pick
  import rr_arbiter_pkg::*;
#(
  parameter  int SIZE = 4,
  localparam int IW   = idx_w(SIZE)
) (
  input  logic [SIZE-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [SIZE-1:0] exclude,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [SIZE-1:0] cand;
  logic [SIZE-1:0] masked;
  logic [SIZE-1:0] src;

  always_comb begin
    cand   = req & ~exclude;
    masked = '0;
    for (int i = 0; i < SIZE; i++) begin
      masked[i] = cand[i] && (i < int'(ptr));
    end
    src    = (|masked) ? masked : cand;
    winner = '0;
    // Ascending scan so the highest set index is the last one written.
    for (int i = 0; i < SIZE; i++) begin
      if (src[i]) winner = IW'(i);
    end
    any = |cand;
  end

endmodule

// File: rtl/rr_arbiter_burst_lock.sv
// Registered round-robin arbiter with MSB-first tie-break and a burst lock
// held until the grantee's last beat or the beat limit.
module rr_arbiter_burst_lock
  import rr_arbiter_pkg::*;
#(
  parameter  int SIZE      = 4,
  parameter  int MAX_BEATS = 8,
  localparam int IW        = idx_w(SIZE),
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIZE-1:0]         req,
  input  logic [SIZE-1:0]         req_last,
  input  logic                    out_ready,
  output logic [SIZE-1:0]         gnt,
  output logic [$clog2(SIZE)-1:0] gnt_id,
  output logic                    busy,
  output logic                    fire
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   beat_q, beat_d;

  logic            release_beat;
  logic [IW-1:0]   pick_ptr;
  logic [SIZE-1:0] pick_excl;
  logic [IW-1:0]   pick_winner;
  logic            pick_any;

  assign busy         = (state_q == LOCK);
  assign fire         = busy & req[gnt_id_q] & out_ready;
  assign release_beat = fire & (req_last[gnt_id_q] | (beat_q == CW'(MAX_BEATS - 1)));

  // On release the picker already sees the new pointer and skips the
  // outgoing grantee, so handover costs no bubble.
  assign pick_ptr  = release_beat ? gnt_id_q : ptr_q;
  assign pick_excl = release_beat ? (SIZE'(1) << gnt_id_q) : '0;

  rr_mask_pick #(.SIZE(SIZE)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .exclude (pick_excl),
    .winner  (pick_winner),
    .any     (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = LOCK;
          gnt_d    = SIZE'(1) << pick_winner;
          gnt_id_d = pick_winner;
          beat_d   = '0;
        end
      end
      LOCK: begin
        if (release_beat) begin
          ptr_d  = gnt_id_q;
          beat_d = '0;
          if (pick_any) begin
            gnt_d    = SIZE'(1) << pick_winner;
            gnt_id_d = pick_winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (fire) begin
          beat_d = beat_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = $clog2(SIZE)'(gnt_id_q);

endmodule

// File: tb/tb_rr_arbiter_burst_lock.sv
// Bench for rr_arbiter_burst_lock: directed vector table, hand-written corner
// sequences and random traffic against a rotating-priority reference model.
module tb_rr_arbiter_burst_lock;

  localparam int SIZE      = 4;
  localparam int MAX_BEATS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] req = '0;
  logic [SIZE-1:0] req_last = '0;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            fire;

  rr_arbiter_burst_lock #(.SIZE(SIZE), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_last  (req_last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .fire      (fire)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds the resource, how many beats it has moved,
  // and which requester last released.
  bit m_busy;
  int m_id;
  int m_ptr;
  int m_beats;

  typedef struct {
    logic [SIZE-1:0] req;
    logic [SIZE-1:0] last;
    logic            rdy;
    logic [SIZE-1:0] gnt;
    logic            busy;
    logic            fire;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Priority walks downward from just below the last releaser, wrapping.
  function automatic int ref_pick(input logic [SIZE-1:0] r, input int ptr, input int excl);
    int res = -1;
    for (int k = 1; k <= SIZE; k++) begin
      int idx = (ptr - k + SIZE) % SIZE;
      if (res < 0 && idx != excl && r[idx]) res = idx;
    end
    return res;
  endfunction

  function automatic bit model_fire();
    return m_busy && req[m_id] && out_ready;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_id    = 0;
    m_ptr   = 0;
    m_beats = 0;
  endtask

  // Apply one clock edge's worth of arbitration to the model.
  task automatic model_step();
    int w;
    if (!m_busy) begin
      w = ref_pick(req, m_ptr, -1);
      if (w >= 0) begin
        m_busy  = 1;
        m_id    = w;
        m_beats = 0;
      end
    end else if (model_fire()) begin
      m_beats++;
      if (req_last[m_id] || m_beats == MAX_BEATS) begin
        m_ptr = m_id;
        w = ref_pick(req, m_ptr, m_id);
        if (w >= 0) begin
          m_id    = w;
          m_beats = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  // Wait to the negedge and compare DUT outputs against the model.
  task automatic sample();
    @(negedge clk);
    chk("model_gnt", int'(gnt), m_busy ? (1 << m_id) : 0);
    chk("model_busy", int'(busy), int'(m_busy));
    chk("model_fire", int'(fire), int'(model_fire()));
    if (m_busy) chk("model_gnt_id", int'(gnt_id), m_id);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    req_last  = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fire", int'(fire), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    bit done;

    // req, last, rdy -> gnt, busy, fire (as seen during that cycle)
    tbl[0]  = '{4'b0101, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1};
    tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1};
    tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1};
    tbl[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1};
    tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
    tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      req       = tbl[i].req;
      req_last  = tbl[i].last;
      out_ready = tbl[i].rdy;
      sample();
      chk($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_fire", i), int'(fire), int'(tbl[i].fire));
      advance();
    end

    // Beat limit: requester 3 moves exactly MAX_BEATS beats, then hands to 0.
    do_reset();
    req = 4'b1001; req_last = '0; out_ready = 1'b1;
    sample();
    chk("beat_idle", int'(busy), 0);
    advance();
    for (int i = 0; i < MAX_BEATS; i++) begin
      sample();
      chk("beat_gnt", int'(gnt), 4'b1000);
      chk("beat_fire", int'(fire), 1);
      advance();
    end
    sample();
    chk("beat_handover", int'(gnt), 4'b0001);
    advance();

    // Backpressure: grant frozen while stalled, beat count preserved.
    do_reset();
    req = 4'b0100; req_last = '0; out_ready = 1'b1;
    sample(); advance();
    sample();
    chk("bp_first_fire", int'(fire), 1);
    advance();
    req = 4'b1100; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_gnt_hold", int'(gnt), 4'b0100);
      chk("bp_no_fire", int'(fire), 0);
      advance();
    end
    out_ready = 1'b1;
    cnt  = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      if (gnt != 4'b0100) done = 1;
      else begin
        if (fire) cnt++;
        advance();
      end
    end
    chk("bp_done_in_time", int'(done), 1);
    chk("bp_remaining_beats", cnt, MAX_BEATS - 1);
    chk("bp_next_gnt", int'(gnt), 4'b1000);
    advance();

    // Sole requester: one-cycle bubble between repeated single-beat bursts.
    do_reset();
    req = 4'b0010; req_last = 4'b0010; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("sole_gnt", int'(gnt), (i % 2 == 1) ? 4'b0010 : 4'b0000);
      chk("sole_busy", int'(busy), i % 2);
      advance();
    end

    // Async reset mid-burst, then MSB-first pick afterwards.
    do_reset();
    req = 4'b0010; req_last = '0; out_ready = 1'b1;
    sample(); advance();
    for (int i = 0; i < 3; i++) begin
      sample(); advance();
    end
    sample();
    chk("ar_pre_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("ar_gnt", int'(gnt), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_fire", int'(fire), 0);
    req = 4'b1010;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    chk("ar_idle", int'(gnt), 0);
    advance();
    sample();
    chk("ar_msb_first", int'(gnt), 4'b1000);
    advance();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req       = SIZE'($urandom_range(0, 15));
      req_last  = SIZE'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_burst_lock.md
# rr_arbiter_burst_lock

Registered round-robin arbiter that shares one downstream resource among SIZE requesters, with MSB-first tie-breaking and a burst lock that holds a grant until the requester's last beat or a beat limit. It sits between the requester ports and the shared resource's valid/ready input. It is the sequential companion to the team's combinational fixed-priority MSB-to-LSB arbiter.

## Interface
- SIZE, 4, number of requesters (≥2)
- MAX_BEATS, 8, maximum beats per grant before forced rotation (≥1)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  SIZE  per-requester request/valid
- req_last  input  SIZE  per-requester last-beat flag, sampled only on a transfer
- out_ready  input  1  shared resource accepts a beat this cycle
- gnt  output  SIZE  one-hot grant, registered
- gnt_id  output  $clog2(SIZE)  index of granted requester, valid when busy
- busy  output  1  a grant is held (state LOCK)
- fire  output  1  beat transfer this cycle: busy & req[gnt_id] & out_ready

## Operation
- States: IDLE, LOCK. Reset: IDLE, gnt=0, gnt_id=0, busy=0, ptr=0, beat_cnt=0.
- Pick function (combinational): masked = req & mask(ptr), where mask(ptr) has bits [ptr-1:0] set; if masked ≠ 0, winner = highest set index of masked; else winner = highest set index of req. ptr=0 → empty mask → plain MSB-first.
- IDLE: if req≠0, load gnt=onehot(winner), gnt_id=winner, beat_cnt=0, go LOCK. Else stay.
- LOCK: grant frozen regardless of req changes. On fire, beat_cnt increments.
- Release condition: fire & (req_last[gnt_id] | beat_cnt==MAX_BEATS-1).
- On release: ptr←gnt_id; pick re-evaluated the same cycle with the new ptr and with req[gnt_id] excluded; if another request is present, load new grant directly (stay LOCK, beat_cnt=0); else go IDLE, gnt=0.
- Granted requester dropping req mid-burst: no fire, grant held, beat_cnt unchanged.
- beat_cnt width $clog2(MAX_BEATS+1); never exceeds MAX_BEATS-1.
- gnt is always zero or one-hot; gnt_id matches gnt whenever busy.

## Timing
- Request-to-grant latency: 1 cycle (req high in IDLE at edge N → gnt high after edge N).
- Back-to-back handover: release beat at edge N, next grantee's gnt visible after edge N; no bubble.
- fire is combinational from registered gnt/gnt_id and live req/out_ready.
- Single requester bursting repeatedly: after release it is excluded for one pick; if alone, goes IDLE for 1 cycle, then regranted (1-cycle bubble).
- MAX_BEATS=1: every fire releases.
- Async rst mid-burst: all outputs 0 immediately, ptr=0; first post-reset pick is MSB-first.

## Structure
- Package rr_arbiter_pkg: state enum (IDLE, LOCK), index-width helper function.
- Sub-module rr_mask_pick: combinational masked MSB-first pick (req, ptr, exclude → winner index, any); instantiated once, used in IDLE and on release.
- Top module holds state register, gnt/gnt_id/ptr/beat_cnt registers, release logic.

## Test plan
- Reset then req=4'b0101, out_ready=1, req_last=4'b0100 → gnt=4'b0100 one cycle later, one fire releases, next cycle gnt=4'b0001.
- Round robin: req=4'b1111 held, req_last=4'b1111, out_ready=1 → grant sequence 3,2,1,0,3 on consecutive cycles, no bubbles.
- Beat limit: SIZE=4, MAX_BEATS=8, req=4'b1001, req_last=0 → requester 3 gets exactly 8 fires, then gnt=4'b0001 next cycle.
- Backpressure/lock: granted id 2, out_ready=0 for 5 cycles while req[3] rises → gnt stays 4'b0100, fire=0, beat_cnt unchanged.
- Sole requester: req=4'b0010, req_last=1 each beat → gnt 1 for one cycle, 0 for one cycle, repeating; busy toggles accordingly.
- Async reset asserted mid-burst at beat 3 of id 1 → gnt=0, busy=0 without clock edge; after release with req=4'b1010 → gnt=4'b1000.
